// File: rtl/if_id_stage.sv
// if_id_stage: fetch/decode pipeline register with static branch predecode and perf counters.
module if_id_stage #(
  parameter logic [63:0] PC_RST     = 64'h0000000080000000,
  parameter logic        PREDICT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        id_stall,
  input  logic        flush_en,
  output logic        if_pc_stall,
  output logic        prdt_pc_en,
  output logic [63:0] prdt_pc_add_op,
  output logic        id_valid,
  output logic [63:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_prdt_taken,
  output logic [63:0] id_prdt_target,
  output logic [63:0] cnt_fetch,
  output logic [63:0] cnt_prdt,
  output logic [63:0] cnt_flush
);
  localparam logic [31:0] NOP = 32'h00000013;
  logic        is_jal, is_bbk, taken_raw;
  logic [63:0] j_imm, b_imm, offset;
  logic        valid_q, taken_q;
  logic [63:0] pc_q, target_q, fetch_q, prdt_q, flush_q;
  logic [31:0] inst_q;
  // Only backward conditional branches are guessed taken (loop heuristic).
  assign is_jal         = if_inst[6:0] == 7'b1101111;
  assign is_bbk         = if_inst[6:0] == 7'b1100011 && if_inst[31];
  assign taken_raw      = is_jal | is_bbk;
  assign j_imm          = {{44{if_inst[31]}}, if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};
  assign b_imm          = {{52{if_inst[31]}}, if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign offset         = is_jal ? j_imm : b_imm;
  assign prdt_pc_en     = PREDICT_EN && taken_raw && !rst && !flush_en && !id_stall;
  assign prdt_pc_add_op = prdt_pc_en ? offset : 64'd0;
  assign if_pc_stall    = id_stall & ~flush_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= PC_RST;
      inst_q   <= NOP;
      taken_q  <= 1'b0;
      target_q <= 64'd0;
      fetch_q  <= 64'd0;
      prdt_q   <= 64'd0;
      flush_q  <= 64'd0;
    end else if (flush_en) begin
      valid_q  <= 1'b0;
      inst_q   <= NOP;
      taken_q  <= 1'b0;
      target_q <= 64'd0;
      flush_q  <= flush_q + 64'd1;
    end else if (!id_stall) begin
      valid_q  <= 1'b1;
      pc_q     <= if_pc;
      inst_q   <= if_inst;
      taken_q  <= prdt_pc_en;
      target_q <= if_pc + (prdt_pc_en ? offset : 64'd4);
      fetch_q  <= fetch_q + 64'd1;
      prdt_q   <= prdt_q + {63'd0, prdt_pc_en};
    end
  end
  assign id_valid       = valid_q;
  assign id_pc          = pc_q;
  assign id_inst        = inst_q;
  assign id_prdt_taken  = taken_q;
  assign id_prdt_target = target_q;
  assign cnt_fetch      = fetch_q;
  assign cnt_prdt       = prdt_q;
  assign cnt_flush      = flush_q;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed vectors feed a scoreboard queue; a monitor pops and compares each cycle.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] if_pc = 64'd0;
  logic [31:0] if_inst = 32'h00000013;
  logic        id_stall = 1'b0;
  logic        flush_en = 1'b0;
  logic        if_pc_stall, prdt_pc_en, id_valid, id_prdt_taken;
  logic [63:0] prdt_pc_add_op, id_pc, id_prdt_target, cnt_fetch, cnt_prdt, cnt_flush;
  logic [31:0] id_inst;

  if_id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .id_stall(id_stall),
    .flush_en(flush_en), .if_pc_stall(if_pc_stall), .prdt_pc_en(prdt_pc_en),
    .prdt_pc_add_op(prdt_pc_add_op), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_prdt_taken(id_prdt_taken), .id_prdt_target(id_prdt_target),
    .cnt_fetch(cnt_fetch), .cnt_prdt(cnt_prdt), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        prdt_en;
    logic [63:0] add;
    logic        pcst;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [63:0] tgt;
    logic [63:0] cf, cp, cfl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  logic        m_valid, m_taken;
  logic [63:0] m_pc, m_tgt, m_cf, m_cp, m_cfl;
  logic [31:0] m_inst;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] JAL16   = 32'h010000EF;
  localparam logic [31:0] JALM8   = 32'hFF9FF0EF;
  localparam logic [31:0] BEQM8   = 32'hFE000CE3;
  localparam logic [31:0] BEQP8   = 32'h00000463;
  localparam logic [31:0] ADDI    = 32'h00100093;
  localparam logic [63:0] M8      = 64'hFFFFFFFFFFFFFFF8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // tk/off are the hand-decoded prediction and offset of inst; fc presets cnt_fetch to all-ones
  task automatic step(input logic r, s, f, input logic [63:0] pc, input logic [31:0] inst,
                      input logic tk, input logic [63:0] off, input logic fc);
    exp_t e;
    logic en;
    @(negedge clk);
    if (fc) begin
      dut.fetch_q = '1;
      m_cf = '1;
    end
    rst = r; id_stall = s; flush_en = f; if_pc = pc; if_inst = inst;
    en = tk & !r & !f & !s;
    e.prdt_en = en;
    e.add = en ? off : 64'd0;
    e.pcst = s & !f;
    if (r) begin
      m_valid = 0; m_pc = 64'h80000000; m_inst = NOP; m_taken = 0; m_tgt = 0;
      m_cf = 0; m_cp = 0; m_cfl = 0;
    end else if (f) begin
      m_valid = 0; m_inst = NOP; m_taken = 0; m_tgt = 0; m_cfl = m_cfl + 1;
    end else if (!s) begin
      m_valid = 1; m_pc = pc; m_inst = inst; m_taken = en;
      m_tgt = pc + (en ? off : 64'd4);
      m_cf = m_cf + 1;
      if (en) m_cp = m_cp + 1;
    end
    e.valid = m_valid; e.pc = m_pc; e.inst = m_inst; e.taken = m_taken; e.tgt = m_tgt;
    e.cf = m_cf; e.cp = m_cp; e.cfl = m_cfl;
    q.push_back(e);
  endtask

  initial begin
    logic        a_en, a_pcst;
    logic [63:0] a_add;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      a_en = prdt_pc_en; a_add = prdt_pc_add_op; a_pcst = if_pc_stall;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("prdt_pc_en", {63'd0, a_en}, {63'd0, e.prdt_en});
        chk("prdt_pc_add_op", a_add, e.add);
        chk("if_pc_stall", {63'd0, a_pcst}, {63'd0, e.pcst});
        chk("id_valid", {63'd0, id_valid}, {63'd0, e.valid});
        chk("id_pc", id_pc, e.pc);
        chk("id_inst", {32'd0, id_inst}, {32'd0, e.inst});
        chk("id_prdt_taken", {63'd0, id_prdt_taken}, {63'd0, e.taken});
        chk("id_prdt_target", id_prdt_target, e.tgt);
        chk("cnt_fetch", cnt_fetch, e.cf);
        chk("cnt_prdt", cnt_prdt, e.cp);
        chk("cnt_flush", cnt_flush, e.cfl);
      end
    end
  end

  initial begin
    step(1, 0, 0, 64'h0, NOP, 0, 0, 0);
    step(1, 0, 0, 64'h0, NOP, 0, 0, 0);
    step(0, 0, 0, 64'h80000000, JAL16, 1, 64'd16, 0);
    step(0, 0, 0, 64'h80000020, BEQM8, 1, M8, 0);
    step(0, 0, 0, 64'h80000024, BEQP8, 0, 0, 0);
    step(0, 0, 0, 64'h80000028, ADDI, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 64'h8000002C, JAL16, 1, 64'd16, 0);
    step(0, 1, 1, 64'h8000002C, JAL16, 1, 64'd16, 0);
    step(0, 0, 1, 64'h80000100, ADDI, 0, 0, 0);
    step(0, 0, 0, 64'h80000200, JALM8, 1, M8, 0);
    step(0, 0, 0, 64'h80000204, ADDI, 0, 0, 0);
    step(0, 0, 0, 64'h80000208, BEQM8, 1, M8, 0);
    step(0, 0, 0, 64'h8000020C, BEQP8, 0, 0, 0);
    step(0, 0, 0, 64'h0, JALM8, 1, M8, 0);
    step(1, 1, 1, 64'h80000300, JAL16, 1, 64'd16, 0);
    step(0, 0, 0, 64'h80000400, JAL16, 1, 64'd16, 0);
    step(0, 1, 0, 64'h80000404, ADDI, 0, 0, 0);
    step(0, 0, 0, 64'h80000408, ADDI, 0, 0, 1);
    step(0, 0, 0, 64'h8000040C, ADDI, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: ysyx_22050598_if_id_stage

Interface
REQ-001 SHALL have parameter PC_RST, default 64'h0000000080000000, reset value of id_pc.
REQ-002 SHALL have parameter PREDICT_EN, default 1; when 0, static prediction is disabled.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_pc  input  64  PC of the instruction fetched this cycle.
REQ-006 SHALL have port if_inst  input  32  instruction fetched this cycle.
REQ-007 SHALL have port id_stall  input  1  downstream hold request.
REQ-008 SHALL have port flush_en  input  1  mispredict/redirect from execute.
REQ-009 SHALL have port if_pc_stall  output  1  PC hold to fetch stage.
REQ-010 SHALL have port prdt_pc_en  output  1  prediction valid to fetch stage.
REQ-011 SHALL have port prdt_pc_add_op  output  64  sign-extended PC offset to fetch stage.
REQ-012 SHALL have ports id_valid (output, 1), id_pc (output, 64) and id_inst (output, 32): decode-stage instruction valid flag, PC and instruction.
REQ-013 SHALL have ports id_prdt_taken (output, 1) and id_prdt_target (output, 64): registered prediction and predicted target.
REQ-014 SHALL have ports cnt_fetch, cnt_prdt and cnt_flush (output, 64 each): performance counters.

Function
REQ-015 Predecode SHALL be combinational on if_inst: JAL (opcode 1101111) is predicted taken with offset = sign-extended J-immediate.
REQ-016 B-type (opcode 1100011) with inst[31]=1 (backward) SHALL be predicted taken with offset = sign-extended B-immediate; forward branches are not taken.
REQ-017 All other opcodes SHALL be predicted not taken, giving prdt_pc_en=0 and prdt_pc_add_op=0.
REQ-018 prdt_pc_en SHALL be forced to 0 when rst, flush_en, id_stall or PREDICT_EN=0 is active, and prdt_pc_add_op SHALL be 0 whenever prdt_pc_en=0.
REQ-019 if_pc_stall SHALL equal id_stall & ~flush_en, combinationally.
REQ-020 Register update priority SHALL be rst > flush_en > id_stall > load.
REQ-021 Load (no rst, flush or stall) SHALL, at the next edge, set id_valid=1, id_pc=if_pc, id_inst=if_inst and id_prdt_taken=prediction, with id_prdt_target = if_pc + offset when taken and if_pc + 4 when not; one-cycle latency.
REQ-022 Flush SHALL, at the next edge, set id_valid=0, id_inst=32'h00000013, id_prdt_taken=0 and id_prdt_target=0, and hold id_pc.
REQ-023 Flush and stall asserted together SHALL be treated as a flush.
REQ-024 Stall SHALL hold all id_* registers unchanged for as many cycles as id_stall stays high.
REQ-025 Adds SHALL be 64-bit modulo 2^64, with no overflow flag.
REQ-026 cnt_fetch SHALL increment by 1 on every load edge.
REQ-027 cnt_prdt SHALL increment by 1 on every load edge with prediction taken.
REQ-028 cnt_flush SHALL increment by 1 on every edge with flush_en=1 and rst=0.
REQ-029 All counters SHALL wrap from 2^64-1 to 0.

Reset
REQ-030 On a rst edge, the block SHALL set id_valid=0, id_pc=PC_RST, id_inst=32'h00000013, id_prdt_taken=0, id_prdt_target=0 and cnt_fetch, cnt_prdt, cnt_flush=0.
REQ-031 rst asserted during a stall or flush SHALL override it at the same edge.
REQ-032 Outputs SHALL be valid at the first edge after rst deasserts.

Verification
REQ-033 Bench SHALL cover: if_pc=0x80000000, if_inst=0x010000EF (jal +16) -> same cycle prdt_pc_en=1, add_op=16; next edge id_valid=1, id_prdt_taken=1, id_prdt_target=0x80000010, cnt_prdt=1.
REQ-034 Bench SHALL cover: if_inst=0xFE000CE3 (beq -8) at if_pc=0x80000020 -> add_op=0xFFFFFFFFFFFFFFF8, id_prdt_target=0x80000018; if_inst=0x00000463 (beq +8) -> prdt_pc_en=0, id_prdt_target=if_pc+4.
REQ-035 Bench SHALL cover: id_stall=1 for 3 cycles with jal on if_inst -> prdt_pc_en=0, if_pc_stall=1, id_* held, cnt_fetch unchanged.
REQ-036 Bench SHALL cover: flush_en=1 together with id_stall=1 -> if_pc_stall=0; next edge id_valid=0, id_inst=0x00000013, cnt_flush+1.
REQ-037 Bench SHALL cover: rst=1 mid-stream after 5 loads -> next edge all counters 0, id_pc=0x80000000, id_valid=0.
REQ-038 Bench SHALL cover: cnt_fetch forced to 2^64-1 then one load -> cnt_fetch=0.
